// File: rtl/t02_wb_pkg.sv
// Shared types and constants for the Wishbone B4 classic master bridge.
package t02_wb_pkg;

   typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_DONE} wb_state_t;

   localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
   localparam logic [31:0] WB_ERR_DATA = 32'hBAD1_BAD1;

endpackage

// File: rtl/t02_wb_master.sv
// Single-port RAM request -> one Wishbone B4 classic cycle, with ACK timeout.
// CYC/STB/busy are decoded from the state register, so an async reset drops
// the bus cycle immediately without waiting for a clock edge.
module t02_wb_master
   import t02_wb_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = WB_ERR_DATA
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        Ren,
   input  logic        Wen,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic        busy_o,
   output logic        bus_err,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   output logic [31:0] ADR_O,
   output logic [31:0] DAT_O,
   output logic [3:0]  SEL_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK_I
);

   // Counter value seen in the last REQ cycle before the abort.
   localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   wb_state_t   r_state;
   logic [15:0] r_cnt;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic        r_we;
   logic [31:0] r_load;
   logic        r_err;

   logic        w_req;
   logic        w_idle;
   logic        w_in_req;
   logic        w_timeout;

   assign w_req     = Ren | Wen;
   assign w_idle    = (r_state == WB_IDLE);
   assign w_in_req  = (r_state == WB_REQ);
   assign w_timeout = (r_cnt == LP_TO_LAST);

   // Control FSM: IDLE -> REQ on request, REQ -> DONE on ACK or timeout, DONE -> IDLE.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= WB_IDLE;
      end else begin
         case (r_state)
            WB_IDLE: if (w_req)               r_state <= WB_REQ;
            WB_REQ:  if (ACK_I || w_timeout)  r_state <= WB_DONE;
            WB_DONE:                          r_state <= WB_IDLE;
            default:                          r_state <= WB_IDLE;
         endcase
      end
   end

   // Latch the request on acceptance; Wen wins when both strobes are high.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_adr <= 32'h0;
         r_dat <= 32'h0;
         r_we  <= 1'b0;
      end else if (w_idle && w_req) begin
         r_adr <= ramaddr;
         r_dat <= ramstore;
         r_we  <= Wen;
      end
   end

   // Timeout counter: cleared on acceptance, counts unacknowledged REQ cycles, saturates.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cnt <= 16'h0;
      end else if (w_idle && w_req) begin
         r_cnt <= 16'h0;
      end else if (w_in_req && !ACK_I && !w_timeout && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'h1;
      end
   end

   // Completion: ACK takes priority over a simultaneous timeout; error flag is sticky.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_load <= 32'h0;
         r_err  <= 1'b0;
      end else if (w_in_req) begin
         if (ACK_I) begin
            if (!r_we) r_load <= DAT_I;
         end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_we) r_load <= ERR_DATA;
         end
      end
   end

   assign CYC_O   = w_in_req;
   assign STB_O   = w_in_req;
   assign WE_O    = r_we;
   assign ADR_O   = r_adr;
   assign DAT_O   = r_dat;
   assign SEL_O   = WB_SEL_ALL;
   assign ramload = r_load;
   assign bus_err = r_err;
   assign busy_o  = w_in_req | (w_idle & w_req);

endmodule

// File: tb/tb_t02_wb_master.sv
// Bench for t02_wb_master: two instances (timeout 8 and 4) share stimulus;
// a transaction-level model predicts every output each cycle.
module tb_t02_wb_master;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        Ren = 1'b0;
   logic        Wen = 1'b0;
   logic        ACK_I = 1'b0;
   logic [31:0] ramaddr = 32'h0;
   logic [31:0] ramstore = 32'h0;
   logic [31:0] DAT_I = 32'h0;

   logic [1:0]       cyc, stb, we, busy, err;
   logic [1:0][31:0] adr, dat, load;
   logic [1:0][3:0]  sel;

   always #5 CLK = ~CLK;

   t02_wb_master #(.TIMEOUT_CYCLES(8)) u_dut8 (
      .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(load[0]), .busy_o(busy[0]), .bus_err(err[0]), .CYC_O(cyc[0]), .STB_O(stb[0]),
      .WE_O(we[0]), .ADR_O(adr[0]), .DAT_O(dat[0]), .SEL_O(sel[0]), .DAT_I(DAT_I), .ACK_I(ACK_I)
   );

   t02_wb_master #(.TIMEOUT_CYCLES(4)) u_dut4 (
      .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(load[1]), .busy_o(busy[1]), .bus_err(err[1]), .CYC_O(cyc[1]), .STB_O(stb[1]),
      .WE_O(we[1]), .ADR_O(adr[1]), .DAT_O(dat[1]), .SEL_O(sel[1]), .DAT_I(DAT_I), .ACK_I(ACK_I)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // ---------------- transaction-level model ----------------
   // on_bus: a bus cycle is outstanding; waited: unacknowledged bus cycles so far;
   // just_done: the cycle after completion, where no new request is taken.
   bit          on_bus[2], just_done[2], m_we[2], m_err[2];
   int          waited[2];
   logic [31:0] m_adr[2], m_dat[2], m_load[2];

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         on_bus[i] = 0; just_done[i] = 0; m_we[i] = 0; m_err[i] = 0; waited[i] = 0;
         m_adr[i] = 32'h0; m_dat[i] = 32'h0; m_load[i] = 32'h0;
      end
   endtask

   task automatic m_step(input int i, input int limit);
      if (just_done[i]) begin
         just_done[i] = 0;
      end else if (on_bus[i]) begin
         if (ACK_I) begin
            if (!m_we[i]) m_load[i] = DAT_I;
            on_bus[i] = 0; just_done[i] = 1;
         end else if (waited[i] + 1 == limit) begin
            m_err[i] = 1;
            if (!m_we[i]) m_load[i] = 32'hBAD1_BAD1;
            on_bus[i] = 0; just_done[i] = 1;
         end else begin
            waited[i]++;
         end
      end else if (Ren || Wen) begin
         on_bus[i] = 1; waited[i] = 0;
         m_adr[i] = ramaddr; m_dat[i] = ramstore; m_we[i] = Wen;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge CLK or negedge nRST);
         if (!nRST) m_reset();
         else begin
            m_step(0, 8);
            m_step(1, 4);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge CLK);
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.cyc", i),  32'(cyc[i]),  32'(on_bus[i]));
            chk($sformatf("u%0d.stb", i),  32'(stb[i]),  32'(on_bus[i]));
            chk($sformatf("u%0d.we", i),   32'(we[i]),   32'(m_we[i]));
            chk($sformatf("u%0d.adr", i),  adr[i],       m_adr[i]);
            chk($sformatf("u%0d.dat", i),  dat[i],       m_dat[i]);
            chk($sformatf("u%0d.sel", i),  32'(sel[i]),  32'h0000_000F);
            chk($sformatf("u%0d.busy", i), 32'(busy[i]),
                32'(on_bus[i] || (!just_done[i] && (Ren || Wen))));
            chk($sformatf("u%0d.load", i), load[i],      m_load[i]);
            chk($sformatf("u%0d.err", i),  32'(err[i]),  32'(m_err[i]));
         end
      end
   end

   // ---------------- stimulus ----------------
   // One request; ACK_I raised during bus cycle number ackk (0 = never). Counts
   // busy cycles, CYC cycles and CYC&WE cycles of instance idx.
   task automatic run(input logic ren, input logic wen, input logic [31:0] a,
                      input logic [31:0] d, input int ackk, input logic [31:0] rd,
                      input int idx, output int nbusy, output int nreq, output int nwe);
      nbusy = 0; nreq = 0; nwe = 0;
      Ren = ren; Wen = wen; ramaddr = a; ramstore = d; DAT_I = rd;
      for (int j = 1; j <= 14; j++) begin
         @(negedge CLK);
         if (busy[idx]) nbusy++;
         if (cyc[idx]) nreq++;
         if (cyc[idx] && we[idx]) nwe++;
         @(posedge CLK); #1;
         Ren = 1'b0; Wen = 1'b0;
         ACK_I = (j == ackk);
      end
      ACK_I = 1'b0;
   endtask

   // Idle cycles with a stray ACK that must be ignored.
   task automatic idle(input int n);
      ACK_I = 1'b1; DAT_I = 32'hFFFF_0000;
      for (int k = 0; k < n; k++) begin
         @(posedge CLK); #1;
         ACK_I = 1'b0; DAT_I = 32'h0;
      end
   endtask

   int nb, nr, nw;
   logic [7:0] pat;

   initial begin
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst.cyc", 32'(cyc[0]), 32'h0);
      chk("rst.load", load[0], 32'h0);
      chk("rst.adr", adr[0], 32'h0);
      nRST = 1'b1;
      @(posedge CLK); #1;

      // read, zero wait states
      run(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 0, nb, nr, nw);
      chk("rd0.busy_cycles", 32'(nb), 32'd2);
      chk("rd0.req_cycles", 32'(nr), 32'd1);
      chk("rd0.load", load[0], 32'hDEAD_BEEF);
      idle(3);

      // write, 3 wait states
      run(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4, 32'h5555_5555, 0, nb, nr, nw);
      chk("wr3.busy_cycles", 32'(nb), 32'd5);
      chk("wr3.req_cycles", 32'(nr), 32'd4);
      chk("wr3.we_cycles", 32'(nw), 32'd4);
      chk("wr3.load_kept", load[0], 32'hDEAD_BEEF);
      idle(3);

      // ACK on the timeout cycle of the 4-cycle instance
      run(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4, 32'hA5A5_A5A5, 1, nb, nr, nw);
      chk("ackto.req_cycles", 32'(nr), 32'd4);
      chk("ackto.load", load[1], 32'hA5A5_A5A5);
      chk("ackto.err", 32'(err[1]), 32'h0);
      idle(3);

      // timeout, ACK never comes
      run(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h0, 0, nb, nr, nw);
      chk("to.req_cycles", 32'(nr), 32'd8);
      chk("to.busy_cycles", 32'(nb), 32'd9);
      chk("to.load", load[0], 32'hBAD1_BAD1);
      chk("to.err", 32'(err[0]), 32'h1);
      idle(3);

      // later good read: error stays sticky
      run(1'b1, 1'b0, 32'h0000_0500, 32'h0, 2, 32'h1357_9BDF, 0, nb, nr, nw);
      chk("rd1.load", load[0], 32'h1357_9BDF);
      chk("rd1.err_sticky", 32'(err[0]), 32'h1);
      idle(3);

      // Ren and Wen together: a single write
      run(1'b1, 1'b1, 32'h0000_0600, 32'hCAFE_F00D, 1, 32'h1111_1111, 0, nb, nr, nw);
      chk("rw.req_cycles", 32'(nr), 32'd1);
      chk("rw.we_cycles", 32'(nw), 32'd1);
      chk("rw.load_kept", load[0], 32'h1357_9BDF);
      idle(3);

      // back-to-back with Ren held: REQ, DONE, IDLE, REQ, ...
      Ren = 1'b1; ramaddr = 32'h0000_0700; ACK_I = 1'b1; DAT_I = 32'h0000_0077;
      for (int j = 0; j < 8; j++) begin
         @(negedge CLK);
         pat[j] = cyc[0];
         @(posedge CLK); #1;
      end
      Ren = 1'b0; ACK_I = 1'b0;
      chk("b2b.cyc_pattern", 32'(pat), 32'h0000_0092);
      idle(4);

      // reset in the middle of a bus cycle
      Ren = 1'b1; ramaddr = 32'h0000_0800;
      @(posedge CLK); #1;
      Ren = 1'b0;
      chk("mid.cyc_before", 32'(cyc[0]), 32'h1);
      #1 nRST = 1'b0;
      #1;
      chk("mid.cyc", 32'(cyc[0]), 32'h0);
      chk("mid.stb", 32'(stb[0]), 32'h0);
      chk("mid.busy", 32'(busy[0]), 32'h0);
      chk("mid.load", load[0], 32'h0);
      chk("mid.err", 32'(err[0]), 32'h0);
      @(negedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;
      chk("post.cyc", 32'(cyc[0]), 32'h0);
      chk("post.load", load[0], 32'h0);

      run(1'b1, 1'b0, 32'h0000_0900, 32'h0, 1, 32'h2468_ACE0, 0, nb, nr, nw);
      chk("post.rd_load", load[0], 32'h2468_ACE0);
      chk("post.err", 32'(err[0]), 32'h0);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
